// File: rtl/if_id_pipe_reg.sv
// IF/ID pipeline register with valid/ready handshake, flush, NOP bubbles,
// optional skid buffer (registered if_ready) and a saturating stall counter.
module if_id_pipe_reg #(
  parameter int unsigned XLEN      = 32,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013,
  parameter bit          SKID_EN   = 1'b1,
  parameter int unsigned CNT_W     = 16
) (
  input  logic             sys_clk,
  input  logic             sys_rst,
  input  logic             flush,
  input  logic             if_valid,
  output logic             if_ready,
  input  logic [XLEN-1:0]  if_now_pc,
  input  logic [XLEN-1:0]  if_pc_plus_4,
  input  logic [XLEN-1:0]  if_instruction,
  output logic             id_valid,
  input  logic             id_ready,
  output logic [XLEN-1:0]  id_now_pc,
  output logic [XLEN-1:0]  id_pc_plus_4,
  output logic [XLEN-1:0]  id_instruction,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam logic [XLEN-1:0] NOP_X = XLEN'(NOP_INSTR);

  // Bit 0 = main entry valid, bit 1 = skid entry valid, so both handshake
  // outputs come straight off a state flop.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_FULL  = 2'b01,
    ST_SKID  = 2'b11
  } state_e;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc4;
    logic [XLEN-1:0] instr;
  } entry_t;

  state_e           state_q, state_d;
  entry_t           main_q, main_d;
  entry_t           skid_q, skid_d;
  entry_t           in_entry;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             stall;

  assign in_entry = '{pc: if_now_pc, pc4: if_pc_plus_4, instr: if_instruction};
  assign id_valid = state_q[0];
  assign stall    = state_q[0] & ~id_ready;

  always_comb begin
    if (SKID_EN) begin
      if_ready = ~state_q[1];
    end else begin
      if_ready = id_ready | ~state_q[0];
    end
  end

  // NOTE: every combinational output gets a default first, so no path
  // through the case statements can leave a signal unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;

    if (flush) begin
      // Redirect: kill everything, show a bubble, keep the PCs for debug.
      state_d      = ST_EMPTY;
      main_d.instr = NOP_X;
    end else if (SKID_EN) begin
      case (state_q)
        ST_EMPTY: begin
          if (if_valid) begin
            state_d = ST_FULL;
            main_d  = in_entry;
          end
        end
        ST_FULL: begin
          if (id_ready && if_valid) begin
            main_d = in_entry;
          end else if (id_ready) begin
            state_d      = ST_EMPTY;
            main_d.instr = NOP_X;
          end else if (if_valid) begin
            state_d = ST_SKID;
            skid_d  = in_entry;
          end
        end
        ST_SKID: begin
          if (id_ready) begin
            state_d = ST_FULL;
            main_d  = skid_q;
          end
        end
        default: begin
          state_d      = ST_EMPTY;
          main_d.instr = NOP_X;
        end
      endcase
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (if_valid) begin
            state_d = ST_FULL;
            main_d  = in_entry;
          end
        end
        ST_FULL: begin
          if (if_valid && id_ready) begin
            main_d = in_entry;
          end else if (id_ready) begin
            state_d      = ST_EMPTY;
            main_d.instr = NOP_X;
          end
        end
        default: begin
          state_d      = ST_EMPTY;
          main_d.instr = NOP_X;
        end
      endcase
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (stall && !flush && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // NOTE: state is updated with non-blocking assignments so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      state_q <= ST_EMPTY;
      main_q  <= '{pc: '0, pc4: '0, instr: NOP_X};
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      cnt_q   <= cnt_d;
    end
  end

  // NOTE: the skid payload has no reset; it is only observed while state_q
  // marks it valid, and that flag is reset above.
  always_ff @(posedge sys_clk) begin
    skid_q <= skid_d;
  end

  assign id_now_pc      = main_q.pc;
  assign id_pc_plus_4   = main_q.pc4;
  assign id_instruction = main_q.instr;
  assign stall_cnt      = cnt_q;

endmodule

// File: tb/tb_if_id_pipe_reg.sv
// Bench for if_id_pipe_reg: a skid-enabled instance and a single-register
// instance with a 4-bit counter, each checked against a queue-based model.
module tb_if_id_pipe_reg;

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] pc4;
    logic [31:0] ins;
  } ent_t;

  logic sys_clk;
  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  int total = 0;
  int bad   = 0;

  // Instance A: SKID_EN=1, CNT_W=16
  logic        a_rst = 1'b1;
  logic        a_flush, a_if_valid, a_if_ready, a_id_valid, a_id_ready;
  logic [31:0] a_now_pc, a_pc4, a_ins, a_id_pc, a_id_pc4, a_id_ins;
  logic [15:0] a_cnt;

  // Instance B: SKID_EN=0, CNT_W=4
  logic        b_rst = 1'b1;
  logic        b_flush, b_if_valid, b_if_ready, b_id_valid, b_id_ready;
  logic [31:0] b_now_pc, b_pc4, b_ins, b_id_pc, b_id_pc4, b_id_ins;
  logic [3:0]  b_cnt;

  if_id_pipe_reg #(.XLEN(32), .NOP_INSTR(32'h0000_0013), .SKID_EN(1'b1), .CNT_W(16)) dut_a (
    .sys_clk(sys_clk), .sys_rst(a_rst), .flush(a_flush),
    .if_valid(a_if_valid), .if_ready(a_if_ready),
    .if_now_pc(a_now_pc), .if_pc_plus_4(a_pc4), .if_instruction(a_ins),
    .id_valid(a_id_valid), .id_ready(a_id_ready),
    .id_now_pc(a_id_pc), .id_pc_plus_4(a_id_pc4), .id_instruction(a_id_ins),
    .stall_cnt(a_cnt)
  );

  if_id_pipe_reg #(.XLEN(32), .NOP_INSTR(32'h0000_0013), .SKID_EN(1'b0), .CNT_W(4)) dut_b (
    .sys_clk(sys_clk), .sys_rst(b_rst), .flush(b_flush),
    .if_valid(b_if_valid), .if_ready(b_if_ready),
    .if_now_pc(b_now_pc), .if_pc_plus_4(b_pc4), .if_instruction(b_ins),
    .id_valid(b_id_valid), .id_ready(b_id_ready),
    .id_now_pc(b_id_pc), .id_pc_plus_4(b_id_pc4), .id_instruction(b_id_ins),
    .stall_cnt(b_cnt)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] ins_of(input logic [31:0] pc);
    return pc ^ 32'h5A5A_0000;
  endfunction

  task automatic drive_a(input logic v, input logic [31:0] pc, input logic idr, input logic fl);
    a_if_valid = v;
    a_now_pc   = pc;
    a_pc4      = pc + 32'd4;
    a_ins      = ins_of(pc);
    a_id_ready = idr;
    a_flush    = fl;
  endtask

  task automatic drive_b(input logic v, input logic [31:0] pc, input logic idr, input logic fl);
    b_if_valid = v;
    b_now_pc   = pc;
    b_pc4      = pc + 32'd4;
    b_ins      = ins_of(pc);
    b_id_ready = idr;
    b_flush    = fl;
  endtask

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic sample();
    @(negedge sys_clk);
  endtask

  // Models: a FIFO of accepted entries (capacity 2 with skid, 1 without);
  // the head is what decode sees, the last shown PCs persist when empty.
  ent_t        ma_q[$];
  logic [31:0] ma_pc = '0, ma_pc4 = '0;
  int          ma_cnt = 0;
  bit          ma_up;

  ent_t        mb_q[$];
  logic [31:0] mb_pc = '0, mb_pc4 = '0;
  int          mb_cnt = 0;
  bit          mb_up;

  always @(posedge sys_clk or negedge a_rst) begin
    if (!a_rst) begin
      ma_q.delete();
      ma_pc  = '0;
      ma_pc4 = '0;
      ma_cnt = 0;
    end else begin
      ma_up = a_if_valid && (ma_q.size() < 2);
      if (ma_q.size() > 0 && !a_id_ready && !a_flush && ma_cnt < 65535) ma_cnt++;
      if (a_flush) begin
        ma_q.delete();
      end else begin
        if (ma_q.size() > 0 && a_id_ready) void'(ma_q.pop_front());
        if (ma_up) ma_q.push_back('{a_now_pc, a_pc4, a_ins});
      end
      if (ma_q.size() > 0) begin
        ma_pc  = ma_q[0].pc;
        ma_pc4 = ma_q[0].pc4;
      end
    end
  end

  always @(posedge sys_clk or negedge b_rst) begin
    if (!b_rst) begin
      mb_q.delete();
      mb_pc  = '0;
      mb_pc4 = '0;
      mb_cnt = 0;
    end else begin
      mb_up = b_if_valid && (mb_q.size() == 0 || b_id_ready);
      if (mb_q.size() > 0 && !b_id_ready && !b_flush && mb_cnt < 15) mb_cnt++;
      if (b_flush) begin
        mb_q.delete();
      end else begin
        if (mb_q.size() > 0 && b_id_ready) void'(mb_q.pop_front());
        if (mb_up) mb_q.push_back('{b_now_pc, b_pc4, b_ins});
      end
      if (mb_q.size() > 0) begin
        mb_pc  = mb_q[0].pc;
        mb_pc4 = mb_q[0].pc4;
      end
    end
  end

  bit seen_200 = 1'b0;

  always @(negedge sys_clk) begin
    if (a_id_valid === 1'b1 && a_id_pc === 32'h200) seen_200 = 1'b1;
    check("a_valid", {31'b0, a_id_valid}, {31'b0, ma_q.size() > 0});
    check("a_if_ready", {31'b0, a_if_ready}, {31'b0, ma_q.size() < 2});
    check("a_pc", a_id_pc, (ma_q.size() > 0) ? ma_q[0].pc : ma_pc);
    check("a_pc4", a_id_pc4, (ma_q.size() > 0) ? ma_q[0].pc4 : ma_pc4);
    check("a_ins", a_id_ins, (ma_q.size() > 0) ? ma_q[0].ins : NOP);
    check("a_cnt", {16'b0, a_cnt}, ma_cnt[31:0]);
    check("b_valid", {31'b0, b_id_valid}, {31'b0, mb_q.size() > 0});
    check("b_if_ready", {31'b0, b_if_ready}, {31'b0, (mb_q.size() == 0) || b_id_ready});
    check("b_pc", b_id_pc, (mb_q.size() > 0) ? mb_q[0].pc : mb_pc);
    check("b_pc4", b_id_pc4, (mb_q.size() > 0) ? mb_q[0].pc4 : mb_pc4);
    check("b_ins", b_id_ins, (mb_q.size() > 0) ? mb_q[0].ins : NOP);
    check("b_cnt", {28'b0, b_cnt}, mb_cnt[31:0]);
  end

  initial begin
    drive_a(1'b0, 32'h0, 1'b1, 1'b0);
    drive_b(1'b0, 32'h0, 1'b1, 1'b0);
    #1;
    a_rst = 1'b0;
    b_rst = 1'b0;
    sample();
    check("lit_rst_valid", {31'b0, a_id_valid}, 32'd0);
    check("lit_rst_ins", a_id_ins, 32'h13);
    check("lit_rst_pc", a_id_pc, 32'h0);
    check("lit_rst_ready", {31'b0, a_if_ready}, 32'd1);
    repeat (3) @(posedge sys_clk);
    #1;
    a_rst = 1'b1;
    b_rst = 1'b1;

    // Back-to-back stream, then drain to empty.
    drive_a(1'b1, 32'h0, 1'b1, 1'b0);
    tick();
    drive_a(1'b1, 32'h4, 1'b1, 1'b0);
    sample();
    check("lit_stream0_valid", {31'b0, a_id_valid}, 32'd1);
    check("lit_stream0_pc", a_id_pc, 32'h0);
    check("lit_stream0_pc4", a_id_pc4, 32'h4);
    tick();
    drive_a(1'b1, 32'h8, 1'b1, 1'b0);
    tick();
    drive_a(1'b1, 32'hC, 1'b1, 1'b0);
    tick();
    drive_a(1'b0, 32'h0, 1'b1, 1'b0);
    sample();
    check("lit_stream3_pc", a_id_pc, 32'hC);
    check("lit_stream3_pc4", a_id_pc4, 32'h10);
    tick();
    sample();
    check("lit_drain_valid", {31'b0, a_id_valid}, 32'd0);
    check("lit_drain_ins", a_id_ins, 32'h13);
    check("lit_drain_pc", a_id_pc, 32'hC);

    // Stall with skid.
    drive_a(1'b1, 32'h100, 1'b1, 1'b0);
    tick();
    drive_a(1'b1, 32'h104, 1'b0, 1'b0);
    sample();
    check("lit_stall_ready0", {31'b0, a_if_ready}, 32'd1);
    tick();
    drive_a(1'b1, 32'h108, 1'b0, 1'b0);
    sample();
    check("lit_skid_ready", {31'b0, a_if_ready}, 32'd0);
    check("lit_skid_pc", a_id_pc, 32'h100);
    check("lit_skid_cnt1", {16'b0, a_cnt}, 32'd1);
    tick();
    tick();
    sample();
    check("lit_skid_cnt3", {16'b0, a_cnt}, 32'd3);
    check("lit_skid_hold_pc", a_id_pc, 32'h100);
    drive_a(1'b1, 32'h108, 1'b1, 1'b0);
    tick();
    sample();
    check("lit_release_pc104", a_id_pc, 32'h104);
    check("lit_release_ready", {31'b0, a_if_ready}, 32'd1);
    tick();
    drive_a(1'b0, 32'h0, 1'b1, 1'b0);
    sample();
    check("lit_release_pc108", a_id_pc, 32'h108);
    tick();

    // Flush while holding a skid entry, with a new entry offered.
    drive_a(1'b1, 32'h180, 1'b1, 1'b0);
    tick();
    drive_a(1'b1, 32'h184, 1'b0, 1'b0);
    tick();
    drive_a(1'b1, 32'h200, 1'b0, 1'b1);
    sample();
    check("lit_preflush_ready", {31'b0, a_if_ready}, 32'd0);
    tick();
    drive_a(1'b0, 32'h0, 1'b1, 1'b0);
    sample();
    check("lit_flush_valid", {31'b0, a_id_valid}, 32'd0);
    check("lit_flush_ins", a_id_ins, 32'h13);
    check("lit_flush_ready", {31'b0, a_if_ready}, 32'd1);
    check("lit_flush_pc", a_id_pc, 32'h180);
    check("lit_flush_cnt", {16'b0, a_cnt}, 32'd4);
    repeat (3) tick();

    // Asynchronous reset in the middle of a skid hold.
    drive_a(1'b1, 32'h300, 1'b1, 1'b0);
    tick();
    drive_a(1'b1, 32'h304, 1'b0, 1'b0);
    tick();
    #2;
    a_rst = 1'b0;
    #1;
    check("lit_arst_valid", {31'b0, a_id_valid}, 32'd0);
    check("lit_arst_ready", {31'b0, a_if_ready}, 32'd1);
    check("lit_arst_cnt", {16'b0, a_cnt}, 32'd0);
    check("lit_arst_pc", a_id_pc, 32'h0);
    drive_a(1'b0, 32'h0, 1'b1, 1'b0);
    tick();
    a_rst = 1'b1;
    drive_a(1'b1, 32'h500, 1'b1, 1'b0);
    tick();
    drive_a(1'b0, 32'h0, 1'b1, 1'b0);
    sample();
    check("lit_post_rst_pc", a_id_pc, 32'h500);
    tick();

    // Single-register variant: combinational if_ready.
    drive_b(1'b1, 32'h400, 1'b1, 1'b0);
    tick();
    drive_b(1'b1, 32'h404, 1'b0, 1'b0);
    sample();
    check("lit_b_ready_low", {31'b0, b_if_ready}, 32'd0);
    check("lit_b_pc400", b_id_pc, 32'h400);
    tick();
    drive_b(1'b1, 32'h404, 1'b1, 1'b0);
    sample();
    check("lit_b_ready_high", {31'b0, b_if_ready}, 32'd1);
    check("lit_b_cnt1", {28'b0, b_cnt}, 32'd1);
    tick();
    drive_b(1'b0, 32'h0, 1'b0, 1'b0);
    sample();
    check("lit_b_pc404", b_id_pc, 32'h404);
    repeat (20) tick();
    sample();
    check("lit_b_sat", {28'b0, b_cnt}, 32'd15);
    drive_b(1'b1, 32'h408, 1'b0, 1'b1);
    tick();
    drive_b(1'b0, 32'h0, 1'b1, 1'b0);
    sample();
    check("lit_b_flush_cnt", {28'b0, b_cnt}, 32'd15);
    check("lit_b_flush_valid", {31'b0, b_id_valid}, 32'd0);
    check("lit_b_flush_ins", b_id_ins, 32'h13);
    drive_b(1'b1, 32'h40C, 1'b1, 1'b1);
    tick();
    drive_b(1'b0, 32'h0, 1'b1, 1'b0);
    sample();
    check("lit_b_flush_drop", {31'b0, b_id_valid}, 32'd0);
    tick();
    #2;
    b_rst = 1'b0;
    #1;
    check("lit_b_rst_cnt", {28'b0, b_cnt}, 32'd0);
    tick();
    b_rst = 1'b1;
    repeat (2) tick();

    check("lit_pc200_dropped", {31'b0, seen_200}, 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
